// File: rtl/hasti_sram_pkg.sv
// Shared types and helpers for the SRAM arbiter slice.
// Holds the state encoding, default widths and byte-mask expansion.
package hasti_sram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;
   localparam int BW_DEF = DW_DEF / 8;

   function automatic logic [DW_DEF-1:0] be2mask(
      input logic [BW_DEF-1:0] be
   );
      logic [DW_DEF-1:0] m;
      m = '0;
      for (int i = 0; i < BW_DEF; i++) begin
         m[i*8 +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/hasti_sram_rr2.sv
// Two-way round-robin arbiter with a last-winner pointer.
// Ties go to the requester that did not win most recently.
module hasti_sram_rr2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic r_last;

   // Grant decode: single requester wins, ties alternate.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   // Remember the last winner; idle cycles leave it alone.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= 1'b1;
      end else if (|o_gnt) begin
         r_last <= o_gnt[1];
      end
   end

endmodule

// File: rtl/hasti_sram_arbiter.sv
// Shares one single-port SRAM between fetch (r0) and data (r1).
// A clear sequencer zero-fills the array after reset or on request.
module hasti_sram_arbiter
   import hasti_sram_pkg::*;
#(
   parameter int AW             = AW_DEF,
   parameter int DW             = DW_DEF,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          init_start,
   output logic          init_busy,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   input  logic [DW/8-1:0] r0_be,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   input  logic [DW/8-1:0] r1_be,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wen,
   output logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_wmask,
   output logic          mem_ren,
   input  logic [DW-1:0] mem_rdata
);

   localparam int BW = DW / 8;
   localparam logic [AW-1:0] LAST = '1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_clr_cnt;
   logic [AW-1:0] w_clr_nxt;
   logic [AW-1:0] r_addr_hold;
   logic          r_rv0;
   logic          r_rv1;

   logic          w_arb_en;
   logic [1:0]    w_req;
   logic [1:0]    w_gnt;
   logic          w_any;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic [BW-1:0] w_be;
   logic [DW-1:0] w_mask;

   assign w_arb_en = RST && (r_state == RUN) && !init_start;
   assign w_req    = {r1_req, r0_req} & {2{w_arb_en}};

   hasti_sram_rr2 u_rr2 (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_req   (w_req),
      .o_gnt   (w_gnt)
   );

   assign w_any   = |w_gnt;
   assign w_we    = w_gnt[1] ? r1_we    : r0_we;
   assign w_addr  = w_gnt[1] ? r1_addr  : r0_addr;
   assign w_wdata = w_gnt[1] ? r1_wdata : r0_wdata;
   assign w_be    = w_gnt[1] ? r1_be    : r0_be;

   if (DW == DW_DEF) begin : g_mask_fn
      assign w_mask = be2mask(w_be);
   end else begin : g_mask_loop
      // Expand each byte enable to a full byte of mask.
      always_comb begin
         w_mask = '0;
         for (int i = 0; i < BW; i++) begin
            w_mask[i*8 +: 8] = {8{w_be[i]}};
         end
      end
   end

   assign r0_gnt    = w_gnt[0];
   assign r1_gnt    = w_gnt[1];
   assign r0_rvalid = r_rv0;
   assign r1_rvalid = r_rv1;
   assign r0_rdata  = r_rv0 ? mem_rdata : '0;
   assign r1_rdata  = r_rv1 ? mem_rdata : '0;
   assign init_busy = (r_state == CLEAR);

   // Next state plus SRAM drive: sweep in CLEAR, winner in RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = r_clr_cnt;
      mem_addr    = r_addr_hold;
      mem_wen     = 1'b0;
      mem_ren     = 1'b0;
      mem_wdata   = '0;
      mem_wmask   = '0;
      unique case (r_state)
         CLEAR: begin
            mem_wen   = 1'b1;
            mem_addr  = r_clr_cnt;
            mem_wmask = '1;
            w_clr_nxt = r_clr_cnt + AW'(1);
            if (r_clr_cnt == LAST) begin
               w_clr_nxt   = '0;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (init_start) begin
               w_state_nxt = CLEAR;
               w_clr_nxt   = '0;
            end else if (w_any) begin
               mem_addr = w_addr;
               if (w_we) begin
                  mem_wen   = 1'b1;
                  mem_wdata = w_wdata;
                  mem_wmask = w_mask;
               end else begin
                  mem_ren = 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (!RST) begin
         mem_wen = 1'b0;
         mem_ren = 1'b0;
      end
   end

   // State, clear counter, held address and read-return flags.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= CLEAR_ON_RESET ? CLEAR : RUN;
         r_clr_cnt   <= '0;
         r_addr_hold <= '0;
         r_rv0       <= 1'b0;
         r_rv1       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_clr_cnt   <= w_clr_nxt;
         r_addr_hold <= mem_addr;
         r_rv0       <= w_gnt[0] & ~r0_we;
         r_rv1       <= w_gnt[1] & ~r1_we;
      end
   end

endmodule

// File: tb/tb_hasti_sram_arbiter.sv
// Directed bench for hasti_sram_arbiter with an SRAM model.
// Read data is checked against a per-requester expectation queue.
module tb_hasti_sram_arbiter;

   logic        CLK;
   logic        RST;
   logic        init_start;
   logic        init_busy;
   logic        r0_req, r0_we;
   logic [9:0]  r0_addr;
   logic [31:0] r0_wdata;
   logic [3:0]  r0_be;
   logic        r0_gnt, r0_rvalid;
   logic [31:0] r0_rdata;
   logic        r1_req, r1_we;
   logic [9:0]  r1_addr;
   logic [31:0] r1_wdata;
   logic [3:0]  r1_be;
   logic        r1_gnt, r1_rvalid;
   logic [31:0] r1_rdata;
   logic [9:0]  mem_addr;
   logic        mem_wen, mem_ren;
   logic [31:0] mem_wdata, mem_wmask, mem_rdata;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   bit          pend0 = 1'b0;
   bit          pend1 = 1'b0;

   logic [31:0] sram [0:1023];
   logic        preload = 1'b1;

   hasti_sram_arbiter #(
      .AW(10), .DW(32), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .CLK(CLK), .RST(RST),
      .init_start(init_start), .init_busy(init_busy),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_be(r0_be), .r0_gnt(r0_gnt),
      .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_be(r1_be), .r1_gnt(r1_gnt),
      .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ren(mem_ren), .mem_rdata(mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // SRAM model: masked write, 1-cycle synchronous read.
   always @(posedge CLK) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) sram[i] <= 32'hA5A5_A5A5;
         preload <= 1'b0;
      end else begin
         if (mem_wen)
            sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask)
                            | (mem_wdata & mem_wmask);
         if (mem_ren)
            mem_rdata <= sram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Return monitor: rvalid exactly one cycle after each read grant.
   always begin
      bit e0, e1;
      @(posedge CLK);
      #2;
      e0 = pend0;
      e1 = pend1;
      pend0 = 1'b0;
      pend1 = 1'b0;
      chk("r0_rvalid", {31'b0, r0_rvalid}, {31'b0, e0});
      chk("r1_rvalid", {31'b0, r1_rvalid}, {31'b0, e1});
      if (e0 && q0.size() > 0) chk("r0_rdata", r0_rdata, q0.pop_front());
      if (e1 && q1.size() > 0) chk("r1_rdata", r1_rdata, q1.pop_front());
   end

   task automatic nx();
      @(negedge CLK);
      #1;
   endtask

   task automatic push(input bit who, input logic [31:0] e);
      if (who) begin
         q1.push_back(e);
         pend1 = 1'b1;
      end else begin
         q0.push_back(e);
         pend0 = 1'b1;
      end
   endtask

   task automatic drv(input bit who, input logic req, input logic we,
                      input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] be);
      if (who) begin
         r1_req = req; r1_we = we; r1_addr = a;
         r1_wdata = d; r1_be = be;
      end else begin
         r0_req = req; r0_we = we; r0_addr = a;
         r0_wdata = d; r0_be = be;
      end
   endtask

   // Lone access; exp is read data for reads, wmask for writes.
   task automatic acc(input bit who, input logic we, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] exp);
      drv(who, 1'b1, we, a, d, be);
      #1;
      chk("gnt_own", {31'b0, who ? r1_gnt : r0_gnt}, 32'd1);
      chk("gnt_other", {31'b0, who ? r0_gnt : r1_gnt}, 32'd0);
      chk("mem_addr", {22'b0, mem_addr}, {22'b0, a});
      if (we) begin
         chk("mem_wen", {31'b0, mem_wen}, 32'd1);
         chk("mem_wmask", mem_wmask, exp);
         chk("mem_wdata", mem_wdata, d);
      end else begin
         chk("mem_ren", {31'b0, mem_ren}, 32'd1);
         chk("mem_wen_rd", {31'b0, mem_wen}, 32'd0);
         push(who, exp);
      end
      nx();
      drv(who, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
   endtask

   // Full sweep: 1024 writes of zero, addresses 0..1023, then RUN.
   task automatic check_clear();
      int bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (init_busy !== 1'b1 || mem_wen !== 1'b1 ||
             mem_addr !== 10'(i) || mem_wdata !== 32'h0 ||
             mem_wmask !== 32'hFFFF_FFFF || r0_gnt !== 1'b0 ||
             r1_gnt !== 1'b0)
            bad++;
         nx();
      end
      chk("clear_sweep", bad, 0);
      chk("clear_len", {31'b0, init_busy}, 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      RST = 1'b0;
      init_start = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      drv(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      repeat (3) nx();

      // In reset with a pending request: nothing issued.
      r0_req = 1'b1;
      #1;
      chk("rst_busy", {31'b0, init_busy}, 32'd1);
      chk("rst_gnt0", {31'b0, r0_gnt}, 32'd0);
      chk("rst_wen", {31'b0, mem_wen}, 32'd0);
      chk("rst_ren", {31'b0, mem_ren}, 32'd0);
      r0_req = 1'b0;
      nx();

      RST = 1'b1;
      #1;
      check_clear();

      // Cleared array reads zero, including the top word.
      acc(1'b1, 1'b0, 10'h123, 32'h0, 4'h0, 32'h0);
      acc(1'b0, 1'b0, 10'h3FF, 32'h0, 4'h0, 32'h0);

      // Partial write then read back.
      acc(1'b1, 1'b1, 10'h055, 32'hDEAD_BEEF, 4'b0101, 32'h00FF_00FF);
      acc(1'b1, 1'b0, 10'h055, 32'h0, 4'h0, 32'h00AD_00EF);

      // Zero byte-enable write is granted but changes nothing.
      acc(1'b1, 1'b1, 10'h055, 32'hFFFF_FFFF, 4'b0000, 32'h0);
      acc(1'b1, 1'b0, 10'h055, 32'h0, 4'h0, 32'h00AD_00EF);

      for (int i = 0; i < 8; i++)
         acc(1'b0, 1'b1, 10'(i), 32'h1000_0000 + 32'(i) * 32'h11,
             4'hF, 32'hFFFF_FFFF);

      // Back-to-back reads from r0 alone.
      r0_req = 1'b1;
      r0_we  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         r0_addr = 10'(i);
         #1;
         chk("b2b_gnt", {31'b0, r0_gnt}, 32'd1);
         push(1'b0, 32'h1000_0000 + 32'(i) * 32'h11);
         nx();
      end
      r0_req = 1'b0;

      // Make r1 the last winner so the first tie goes to r0.
      acc(1'b1, 1'b0, 10'h123, 32'h0, 4'h0, 32'h0);
      drv(1'b0, 1'b1, 1'b0, 10'h001, 32'h0, 4'h0);
      drv(1'b1, 1'b1, 1'b0, 10'h055, 32'h0, 4'h0);
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("rr_gnt0", {31'b0, r0_gnt}, {31'b0, (c % 2) == 0});
         chk("rr_gnt1", {31'b0, r1_gnt}, {31'b0, (c % 2) == 1});
         if (c % 2 == 0) push(1'b0, 32'h1000_0011);
         else push(1'b1, 32'h00AD_00EF);
         nx();
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      #1;
      chk("idle_wen", {31'b0, mem_wen}, 32'd0);
      chk("idle_ren", {31'b0, mem_ren}, 32'd0);
      chk("idle_addr_hold", {22'b0, mem_addr}, 32'h055);
      nx();

      // Idle cycle must not move the pointer: tie goes to r0.
      r0_req = 1'b1;
      r1_req = 1'b1;
      #1;
      chk("rr_after_idle", {30'b0, r1_gnt, r0_gnt}, 32'd1);
      push(1'b0, 32'h1000_0011);
      nx();
      r0_req = 1'b0;
      r1_req = 1'b0;

      // init_start during an r0 read stream.
      drv(1'b0, 1'b1, 1'b0, 10'h002, 32'h0, 4'h0);
      #1;
      chk("pre_init_gnt", {31'b0, r0_gnt}, 32'd1);
      push(1'b0, 32'h1000_0022);
      nx();
      r0_addr = 10'h003;
      init_start = 1'b1;
      #1;
      chk("init_cycle_gnt", {31'b0, r0_gnt}, 32'd0);
      chk("init_cycle_ren", {31'b0, mem_ren}, 32'd0);
      nx();
      init_start = 1'b0;
      n = 0;
      bad = 0;
      while (init_busy === 1'b1 && n < 1100) begin
         if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) bad++;
         n++;
         nx();
      end
      chk("reclear_len", n, 1024);
      chk("reclear_nognt", bad, 0);
      #1;
      chk("held_req_gnt", {31'b0, r0_gnt}, 32'd1);
      push(1'b0, 32'h0);
      nx();
      r0_req = 1'b0;
      acc(1'b1, 1'b0, 10'h055, 32'h0, 4'h0, 32'h0);

      // Reset in the middle of a clear restarts the sweep.
      init_start = 1'b1;
      nx();
      init_start = 1'b0;
      repeat (500) nx();
      #1;
      chk("mid_clear_addr", {22'b0, mem_addr}, 32'd500);
      r1_req = 1'b1;
      RST = 1'b0;
      #1;
      chk("arst_wen", {31'b0, mem_wen}, 32'd0);
      chk("arst_ren", {31'b0, mem_ren}, 32'd0);
      chk("arst_busy", {31'b0, init_busy}, 32'd1);
      chk("arst_gnt", {30'b0, r1_gnt, r0_gnt}, 32'd0);
      chk("arst_rv", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
      r1_req = 1'b0;
      repeat (2) nx();
      RST = 1'b1;
      #1;
      check_clear();

      acc(1'b0, 1'b0, 10'h003, 32'h0, 4'h0, 32'h0);
      acc(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, 32'h0);
      repeat (2) nx();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
